// File: rtl/bsg_manycore_tag_pkg.sv
// Shared types for the host-side bsg_tag serializer: FSM state encoding,
// packet struct generator macro and small elaboration-time helpers.
`ifndef BSG_MANYCORE_TAG_PKG_SV
`define BSG_MANYCORE_TAG_PKG_SV

// Field order puts node_id in the LSBs so a plain right shift serializes
// node, dnr, len, payload in wire order.
`define BSG_TAG_TX_PKT_S(lg_els_mp, lg_w_mp) \
  typedef struct packed { \
    logic [(2**(lg_w_mp))-2:0] payload; \
    logic [(lg_w_mp)-1:0]      len; \
    logic                      data_not_reset; \
    logic [(lg_els_mp)-1:0]    node_id; \
  } bsg_tag_tx_pkt_s

package bsg_manycore_tag_pkg;

  typedef enum logic [2:0] {
    eTagIdle,
    eTagRst,
    eTagStart,
    eTagNode,
    eTagDnr,
    eTagLen,
    eTagPayload,
    eTagGap
  } bsg_tag_tx_state_e;

  function automatic int bsg_safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int bsg_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

`endif

// File: rtl/bsg_manycore_pod_tag_tx.sv
// Serializes parallel bsg_tag packets and master-reset sequences onto the
// registered tag_data_o line, one bit per tag clock.
module bsg_manycore_pod_tag_tx
  import bsg_manycore_tag_pkg::*;
#(
  parameter int tag_els_p      = 1024,
  parameter int tag_lg_width_p = 4,
  parameter int reset_cycles_p = 64,
  parameter int gap_cycles_p   = 2,
  localparam int lg_els_lp     = bsg_safe_clog2(tag_els_p),
  localparam int width_lp      = (2**tag_lg_width_p) - 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      reset_req_v_i,
  input  logic                      pkt_v_i,
  input  logic [lg_els_lp-1:0]      pkt_node_id_i,
  input  logic                      pkt_data_not_reset_i,
  input  logic [tag_lg_width_p-1:0] pkt_len_i,
  input  logic [width_lp-1:0]       pkt_payload_i,
  output logic                      ready_o,
  output logic                      tag_data_o,
  output logic                      busy_o,
  output logic                      len_err_o
);

  `BSG_TAG_TX_PKT_S(lg_els_lp, tag_lg_width_p);

  localparam int cnt_max_lp = bsg_max4(reset_cycles_p, width_lp, lg_els_lp, gap_cycles_p);
  localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);

  localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);
  localparam logic [cnt_w_lp-1:0] cnt_node_lp = cnt_w_lp'(lg_els_lp);
  localparam logic [cnt_w_lp-1:0] cnt_len_lp  = cnt_w_lp'(tag_lg_width_p);
  localparam logic [cnt_w_lp-1:0] cnt_rst_lp  = cnt_w_lp'(reset_cycles_p);
  localparam logic [cnt_w_lp-1:0] cnt_gap_lp  = cnt_w_lp'(gap_cycles_p);

  bsg_tag_tx_state_e         state_q, state_d;
  logic [cnt_w_lp-1:0]       cnt_q, cnt_d;
  bsg_tag_tx_pkt_s           shift_q, shift_d, pkt_in;
  logic [tag_lg_width_p-1:0] len_q, len_d;
  logic                      tag_q, tag_d;
  logic                      last;

  assign pkt_in = '{payload:        pkt_payload_i,
                    len:            pkt_len_i,
                    data_not_reset: pkt_data_not_reset_i,
                    node_id:        pkt_node_id_i};

  assign last = (cnt_q == cnt_one_lp);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    len_d   = len_q;
    tag_d   = 1'b0;

    case (state_q)
      eTagIdle: begin
        if (reset_req_v_i) begin
          state_d = eTagRst;
          cnt_d   = cnt_rst_lp;
        end else if (pkt_v_i) begin
          state_d = eTagStart;
          cnt_d   = cnt_one_lp;
          shift_d = pkt_in;
          len_d   = pkt_len_i;
        end
      end
      eTagStart:   if (last) begin state_d = eTagNode; cnt_d = cnt_node_lp; end
      eTagNode:    if (last) begin state_d = eTagDnr;  cnt_d = cnt_one_lp;  end
      eTagDnr:     if (last) begin state_d = eTagLen;  cnt_d = cnt_len_lp;  end
      eTagLen: begin
        if (last) begin
          if (len_q == '0) begin
            state_d = eTagGap;
            cnt_d   = cnt_gap_lp;
          end else begin
            state_d = eTagPayload;
            cnt_d   = cnt_w_lp'(len_q);
          end
        end
      end
      eTagPayload: if (last) begin state_d = eTagGap;  cnt_d = cnt_gap_lp;  end
      eTagRst:     if (last) begin state_d = eTagGap;  cnt_d = cnt_gap_lp;  end
      eTagGap:     if (last) begin state_d = eTagIdle; cnt_d = '0;          end
      default:     state_d = eTagIdle;
    endcase

    if (state_q != eTagIdle && !last)
      cnt_d = cnt_q - cnt_one_lp;

    // The line register carries the bit belonging to the state being entered.
    case (state_d)
      eTagStart, eTagRst: tag_d = 1'b1;
      eTagNode, eTagDnr, eTagLen, eTagPayload: begin
        tag_d   = shift_q[0];
        shift_d = shift_q >> 1;
      end
      default: tag_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eTagIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      tag_q   <= tag_d;
    end
  end

  assign ready_o    = (state_q == eTagIdle);
  assign busy_o     = (state_q != eTagIdle);
  assign tag_data_o = tag_q;
  // The length field cannot exceed width_lp at this field width.
  assign len_err_o  = 1'b0;

endmodule

// File: tb/tb_bsg_manycore_pod_tag_tx.sv
// Directed bench for bsg_manycore_pod_tag_tx with 64 tag clients.
module tb_bsg_manycore_pod_tag_tx;

  localparam int TAG_ELS = 64;
  localparam int LG_ELS  = 6;
  localparam int LG_W    = 4;
  localparam int WIDTH   = 15;
  localparam int RST_CYC = 64;
  localparam int GAP     = 2;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             reset_req_v_i;
  logic             pkt_v_i;
  logic [LG_ELS-1:0] pkt_node_id_i;
  logic             pkt_data_not_reset_i;
  logic [LG_W-1:0]  pkt_len_i;
  logic [WIDTH-1:0] pkt_payload_i;
  logic             ready_o, tag_data_o, busy_o, len_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  bsg_manycore_pod_tag_tx #(
    .tag_els_p(TAG_ELS), .tag_lg_width_p(LG_W),
    .reset_cycles_p(RST_CYC), .gap_cycles_p(GAP)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .reset_req_v_i(reset_req_v_i),
    .pkt_v_i(pkt_v_i), .pkt_node_id_i(pkt_node_id_i),
    .pkt_data_not_reset_i(pkt_data_not_reset_i), .pkt_len_i(pkt_len_i),
    .pkt_payload_i(pkt_payload_i), .ready_o(ready_o), .tag_data_o(tag_data_o),
    .busy_o(busy_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_stream(input int node, input bit dnr, input int len,
                              input logic [WIDTH-1:0] pay, output bit q[$]);
    q = {};
    q.push_back(1'b1);
    for (int i = 0; i < LG_ELS; i++) q.push_back(node[i]);
    q.push_back(dnr);
    for (int i = 0; i < LG_W; i++) q.push_back(len[i]);
    for (int i = 0; i < len; i++) q.push_back(pay[i]);
    for (int i = 0; i < GAP; i++) q.push_back(1'b0);
  endtask

  task automatic set_pkt(input int node, input bit dnr, input int len, input logic [WIDTH-1:0] pay);
    pkt_node_id_i        = LG_ELS'(node);
    pkt_data_not_reset_i = dnr;
    pkt_len_i            = LG_W'(len);
    pkt_payload_i        = pay;
  endtask

  // Called one cycle after acceptance; leaves the bench in the first IDLE cycle.
  task automatic expect_stream(input string tag, input bit exp[$], input bit scramble);
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("%s bit%0d", tag, i), 32'(tag_data_o), 32'(exp[i]));
      if (i == exp.size() - 1) chk({tag, " busy_last"}, 32'(ready_o), 32'd0);
      if (scramble) pkt_payload_i = WIDTH'($urandom);
      tick();
    end
    chk({tag, " ready_after"}, 32'(ready_o), 32'd1);
  endtask

  bit s_basic[$];
  bit s_zero[$];
  bit s_a[$];
  bit s_b[$];
  bit s_rst[$];
  bit s_all[$];

  initial begin
    reset_i = 1'b1; reset_req_v_i = 1'b0; pkt_v_i = 1'b0;
    set_pkt(0, 1'b0, 0, '0);
    #12;
    chk("rst tag", 32'(tag_data_o), 32'd0);
    chk("rst ready", 32'(ready_o), 32'd1);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst len_err", 32'(len_err_o), 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    tick();

    // idle line after reset
    for (int i = 0; i < 20; i++) begin
      chk("idle tag", 32'(tag_data_o), 32'd0);
      chk("idle ready", 32'(ready_o), 32'd1);
      chk("idle busy", 32'(busy_o), 32'd0);
      tick();
    end

    // basic packet, hand-derived stream
    s_basic = '{1, 1,0,1,0,0,0, 1, 1,1,0,0, 1,0,1, 0,0};
    set_pkt(5, 1'b1, 3, 15'b101);
    pkt_v_i = 1'b1;
    tick();
    pkt_v_i = 1'b0;
    chk("basic busy", 32'(busy_o), 32'd1);
    expect_stream("basic", s_basic, 1'b0);

    // zero length client reset packet
    s_zero = '{1, 1,1,1,1,1,1, 0, 0,0,0,0, 0,0};
    set_pkt(63, 1'b0, 0, 15'h7fff);
    pkt_v_i = 1'b1;
    tick();
    pkt_v_i = 1'b0;
    expect_stream("zlen", s_zero, 1'b0);

    // reset request beats a simultaneous packet; packet is held then sent
    s_rst = {};
    for (int i = 0; i < RST_CYC; i++) s_rst.push_back(1'b1);
    for (int i = 0; i < GAP; i++) s_rst.push_back(1'b0);
    set_pkt(42, 1'b1, 5, 15'b10110);
    build_stream(42, 1'b1, 5, 15'b10110, s_a);
    reset_req_v_i = 1'b1;
    pkt_v_i = 1'b1;
    tick();
    reset_req_v_i = 1'b0;
    expect_stream("rstseq", s_rst, 1'b0);
    tick();
    pkt_v_i = 1'b0;
    expect_stream("held", s_a, 1'b0);

    // back-to-back with input scrambling after acceptance
    build_stream(9, 1'b1, 4, 15'b1011, s_a);
    build_stream(33, 1'b1, 2, 15'b11, s_b);
    s_all = s_a;
    s_all.push_back(1'b0);
    foreach (s_b[i]) s_all.push_back(s_b[i]);
    set_pkt(9, 1'b1, 4, 15'b1011);
    pkt_v_i = 1'b1;
    tick();
    pkt_v_i = 1'b0;
    for (int i = 0; i < s_all.size(); i++) begin
      chk($sformatf("b2b bit%0d", i), 32'(tag_data_o), 32'(s_all[i]));
      if (i == s_a.size()) chk("b2b idle ready", 32'(ready_o), 32'd1);
      if (i < s_a.size() - 1) begin
        pkt_payload_i = WIDTH'($urandom);
        pkt_len_i     = LG_W'($urandom);
      end else if (i == s_a.size() - 1) begin
        set_pkt(33, 1'b1, 2, 15'b11);
        pkt_v_i = 1'b1;
      end else if (i == s_a.size() + 1) begin
        pkt_v_i = 1'b0;
        pkt_payload_i = '0;
      end
      tick();
    end
    chk("b2b ready_after", 32'(ready_o), 32'd1);

    // asynchronous reset in the middle of the payload
    set_pkt(1, 1'b1, 8, 15'hff);
    pkt_v_i = 1'b1;
    tick();
    pkt_v_i = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("mid payload bit", 32'(tag_data_o), 32'd1);
    chk("mid busy", 32'(busy_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async tag", 32'(tag_data_o), 32'd0);
    chk("async ready", 32'(ready_o), 32'd1);
    chk("async busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    tick();
    build_stream(20, 1'b1, 6, 15'b110010, s_a);
    set_pkt(20, 1'b1, 6, 15'b110010);
    pkt_v_i = 1'b1;
    tick();
    pkt_v_i = 1'b0;
    expect_stream("post_rst", s_a, 1'b1);
    chk("final len_err", 32'(len_err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_pod_tag_tx.md
Name: bsg_manycore_pod_tag_tx

Overview:
- Host-side serializer that drives the serial bsg_tag line consumed by the pod's tag master and tag clients.
- Accepts parallel tag packets (node id, data_not_reset, length, payload) over valid/ready and shifts them out one bit per tag clock.
- Also issues a master reset sequence on request.
- Sits in the testbench/host FPGA or a boot-sequencer path, driving tag_data for one or more pods.

Parameters:
- tag_els_p, 1024, number of tag clients addressable; node id width lg_els = `BSG_SAFE_CLOG2(tag_els_p)
- tag_lg_width_p, 4, width of the length field; max payload width_lp = 2**tag_lg_width_p - 1
- reset_cycles_p, 64, number of consecutive 1s sent for a master reset sequence (must be >= 2)
- gap_cycles_p, 2, idle 0 cycles inserted after every packet or reset sequence (>= 1)

Ports:
- clk_i  in  1  tag clock
- reset_i  in  1  asynchronous active-high reset
- reset_req_v_i  in  1  request a master reset sequence
- pkt_v_i  in  1  packet valid
- pkt_node_id_i  in  lg_els  destination client id
- pkt_data_not_reset_i  in  1  1 = data packet, 0 = client reset packet
- pkt_len_i  in  tag_lg_width_p  payload length in bits
- pkt_payload_i  in  width_lp  payload, LSB sent first
- ready_o  out  1  block idle; a request is accepted on (v & ready_o)
- tag_data_o  out  1  serial tag line, registered
- busy_o  out  1  transmission or gap in progress
- len_err_o  out  1  one-cycle pulse: accepted pkt_len_i exceeded width_lp

Behaviour:
- Reset (async):
  - state = IDLE; tag_data_o = 0; ready_o = 1; busy_o = 0; len_err_o = 0; all counters and shift registers = 0.
  - Reset mid-packet aborts immediately and the line returns to 0.
- Idle line level is 0.
- ready_o = (state == IDLE), combinational from state only.
- Acceptance and priority:
  - If reset_req_v_i and pkt_v_i are both high in IDLE, the reset request wins.
  - The packet is not accepted that cycle and must be held by the sender.
- Latency: the first serial bit appears on tag_data_o the cycle after acceptance.
- Packet bit order, one bit per cycle:
  - START: 1
  - NODE: lg_els bits, LSB first
  - DNR: 1 bit
  - LEN: tag_lg_width_p bits, LSB first
  - PAYLOAD: len bits, LSB first
  - GAP: gap_cycles_p zeros
  - then IDLE.
- Packet duration: 1 + lg_els + 1 + tag_lg_width_p + len + gap_cycles_p cycles from the first serial bit to ready_o reasserting.
- len = 0: PAYLOAD is skipped and LEN goes directly to GAP.
- len > width_lp is impossible when the field width is tag_lg_width_p. len_err_o is reserved for tag_lg_width_p configurations where the len input is wider, and is tied 0 in the base configuration.
- Reset sequence: RST state drives 1 for reset_cycles_p cycles, then GAP, then IDLE. The sequence is never interrupted by new requests.
- Registers:
  - Payload, node and length are captured at acceptance. Inputs may change after acceptance without effect.
  - A single down-counter, wide enough for max(reset_cycles_p, width_lp, lg_els, gap_cycles_p), is loaded on each state entry.
  - The state advances when the counter reaches 1.
- busy_o = (state != IDLE).
- Back-to-back: a request valid during the last GAP cycle is accepted in the first IDLE cycle.
  - Minimum spacing between the end of one payload and the next start bit is gap_cycles_p + 1 cycles.
- FSM states: IDLE, RST, START, NODE, DNR, LEN, PAYLOAD, GAP.

Decomposition:
- Shared package bsg_manycore_tag_pkg holds:
  - typedef bsg_tag_tx_pkt_s {payload, len, data_not_reset, node_id}, parameterized by macro on lg_els/tag_lg_width_p
  - state enum bsg_tag_tx_state_e
- Single module. The shift/count datapath is small and stays inline; no sub-module.

Test Plan:
- Post-reset line: release reset_i, hold inputs 0 for 20 cycles -> tag_data_o = 0, ready_o = 1, busy_o = 0 throughout.
- Basic packet (tag_els_p = 64, tag_lg_width_p = 4, gap_cycles_p = 2): node = 5, dnr = 1, len = 3, payload = 3'b101.
  - Required serial stream: 1, 1,0,1,0,0,0, 1, 1,1,0,0, 1,0,1, then 0,0.
  - ready_o reasserts 17 cycles after acceptance.
- Zero length with client reset: node = 63, dnr = 0, len = 0.
  - Required stream: 1, 1,1,1,1,1,1, 0, 0,0,0,0, then 2 gap zeros.
  - 14 cycles total; no payload bits.
- Reset priority: reset_req_v_i and pkt_v_i asserted together in IDLE.
  - Required: 64 consecutive 1s, then 2 zeros.
  - The packet is then accepted and serialized unchanged.
- Back-to-back and input isolation: change pkt_payload_i every cycle after acceptance -> the stream reflects the captured value only. The second packet's start bit follows the first packet's last payload bit by exactly 3 cycles.
- Async reset mid-payload: assert reset_i during the PAYLOAD state -> tag_data_o = 0 and ready_o = 1 immediately, with no clock edge required. The next packet transmits correctly.
